// File: rtl/coin_bank.sv
// Coin credit accumulator feeding the cafea controller's fond input.
// Define COIN_BANK_CHANGE_EN to build the paced change payout; otherwise cancel forfeits the credit.
module coin_bank #(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 31,
  parameter int CHANGE_GAP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                vend_req,
  input  logic [CREDIT_W-1:0] vend_price,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] fond,
  output logic                vend_ack,
  output logic                vend_nak,
  output logic                coin_reject,
  output logic                change_busy,
  output logic                change_pulse
);

  if (CHANGE_GAP < 2 || MAX_CREDIT > (1 << CREDIT_W) - 1) begin : g_bad_params
    $error("coin_bank: CHANGE_GAP must be >= 2 and MAX_CREDIT must fit in CREDIT_W bits");
  end

  logic                r_prev_1, r_prev_2, r_prev_5;
  logic [CREDIT_W-1:0] r_fond;
  logic                r_vend_ack, r_vend_nak, r_coin_reject;

  logic                w_edge_1, w_edge_2, w_edge_5;
  logic                w_coin_any, w_coin_multi;
  logic [2:0]          w_coin_val;
  logic                w_vend_ok, w_cancel_go;
  logic [CREDIT_W-1:0] w_base;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_fits;

  assign w_edge_1     = coin_1 & ~r_prev_1;
  assign w_edge_2     = coin_2 & ~r_prev_2;
  assign w_edge_5     = coin_5 & ~r_prev_5;
  assign w_coin_any   = w_edge_1 | w_edge_2 | w_edge_5;
  assign w_coin_multi = (w_edge_5 & (w_edge_2 | w_edge_1)) | (w_edge_2 & w_edge_1);
  assign w_coin_val   = w_edge_5 ? 3'd5 : (w_edge_2 ? 3'd2 : (w_edge_1 ? 3'd1 : 3'd0));

  // Funds are judged on the old balance; an accepted coin lands on top of the debited value.
  assign w_vend_ok   = (vend_price <= r_fond);
  assign w_base      = (vend_req && w_vend_ok) ? (r_fond - vend_price) : r_fond;
  assign w_sum       = {1'b0, w_base} + (CREDIT_W+1)'(w_coin_val);
  assign w_coin_fits = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_cancel_go = cancel & ~vend_req;

  logic [CREDIT_W-1:0] w_idle_fond;
  logic                w_idle_ack, w_idle_nak, w_idle_rej, w_idle_to_change;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_idle_fond      = w_base;
    w_idle_ack       = vend_req & w_vend_ok;
    w_idle_nak       = vend_req & ~w_vend_ok;
    w_idle_rej       = w_coin_multi;
    w_idle_to_change = 1'b0;
    if (w_cancel_go) begin
      w_idle_rej = w_coin_any;
`ifdef COIN_BANK_CHANGE_EN
      w_idle_to_change = (r_fond != '0);
`else
      w_idle_fond = '0;
`endif
    end else if (w_coin_any) begin
      if (w_coin_fits) w_idle_fond = w_sum[CREDIT_W-1:0];
      else             w_idle_rej  = 1'b1;
    end
  end

`ifdef COIN_BANK_CHANGE_EN
  localparam int GAP_W = $clog2(CHANGE_GAP);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_CHANGE = 1'b1;

  logic [0:0]       r_state;
  logic [GAP_W-1:0] r_gap;
  logic             r_change_pulse;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_gap          <= '0;
      r_fond         <= '0;
      r_prev_1       <= 1'b0;
      r_prev_2       <= 1'b0;
      r_prev_5       <= 1'b0;
      r_vend_ack     <= 1'b0;
      r_vend_nak     <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_change_pulse <= 1'b0;
    end else begin
      r_prev_1 <= coin_1;
      r_prev_2 <= coin_2;
      r_prev_5 <= coin_5;
      case (r_state)
        S_IDLE: begin
          r_fond         <= w_idle_fond;
          r_vend_ack     <= w_idle_ack;
          r_vend_nak     <= w_idle_nak;
          r_coin_reject  <= w_idle_rej;
          r_change_pulse <= 1'b0;
          if (w_idle_to_change) begin
            r_state <= S_CHANGE;
            r_gap   <= GAP_W'(CHANGE_GAP - 1);
          end
        end
        default: begin
          r_vend_ack    <= 1'b0;
          r_vend_nak    <= vend_req;
          r_coin_reject <= w_coin_any;
          if (r_gap == '0) begin
            r_change_pulse <= 1'b1;
            r_fond         <= r_fond - CREDIT_W'(1);
            r_gap          <= GAP_W'(CHANGE_GAP - 1);
            if (r_fond == CREDIT_W'(1)) r_state <= S_IDLE;
          end else begin
            r_change_pulse <= 1'b0;
            r_gap          <= r_gap - GAP_W'(1);
          end
        end
      endcase
    end
  end

  assign change_busy  = (r_state == S_CHANGE);
  assign change_pulse = r_change_pulse;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fond        <= '0;
      r_prev_1      <= 1'b0;
      r_prev_2      <= 1'b0;
      r_prev_5      <= 1'b0;
      r_vend_ack    <= 1'b0;
      r_vend_nak    <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_prev_1      <= coin_1;
      r_prev_2      <= coin_2;
      r_prev_5      <= coin_5;
      r_fond        <= w_idle_fond;
      r_vend_ack    <= w_idle_ack;
      r_vend_nak    <= w_idle_nak;
      r_coin_reject <= w_idle_rej;
    end
  end

  assign change_busy  = 1'b0;
  assign change_pulse = 1'b0;
`endif

  assign fond        = r_fond;
  assign vend_ack    = r_vend_ack;
  assign vend_nak    = r_vend_nak;
  assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_coin_bank.sv
// Scoreboard bench for coin_bank: stimulus queues expected output events, a monitor pops them.
// Exercises the payout path when COIN_BANK_CHANGE_EN is defined, the forfeit path otherwise.
module tb_coin_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_1, coin_2, coin_5, vend_req, cancel;
  logic [4:0] vend_price;
  logic [4:0] fond;
  logic       vend_ack, vend_nak, coin_reject, change_busy, change_pulse;

  coin_bank #(.CREDIT_W(5), .MAX_CREDIT(31), .CHANGE_GAP(4)) dut (
    .clk(clk), .rst(rst),
    .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .vend_req(vend_req), .vend_price(vend_price), .cancel(cancel),
    .fond(fond), .vend_ack(vend_ack), .vend_nak(vend_nak),
    .coin_reject(coin_reject), .change_busy(change_busy), .change_pulse(change_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [9:0] val;  // {ack, nak, reject, pulse, busy, fond}
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_edge = 0;
  bit   mon_en   = 1'b0;
  logic [4:0] prev_fond;
  logic       prev_busy;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Vector sampled at the next rising edge; that edge number is left in last_edge.
  task automatic drv(input bit c1, input bit c2, input bit c5, input bit v,
                     input int price, input bit cn, input bit r);
    @(negedge clk);
    #1;
    coin_1 = c1; coin_2 = c2; coin_5 = c5;
    vend_req = v; vend_price = price[4:0]; cancel = cn; rst = r;
    last_edge = cyc + 1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_to(input int e);
    while (last_edge + 1 < e) idle();
  endtask

  task automatic expect_evt(input int at, input bit ack, input bit nak, input bit rej,
                            input bit pulse, input bit busy, input int f);
    exp_t e;
    e.at  = at;
    e.val = {ack, nak, rej, pulse, busy, f[4:0]};
    q.push_back(e);
  endtask

  // Any pulse or any change of fond/change_busy is an output event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (vend_ack || vend_nak || coin_reject || change_pulse ||
          fond !== prev_fond || change_busy !== prev_busy) begin
        if (q.size() == 0) begin
          check("unexpected_event", {22'd0, vend_ack, vend_nak, coin_reject, change_pulse, change_busy, fond}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_cycle", cyc, e.at);
          check($sformatf("event_at_%0d", e.at),
                {22'd0, vend_ack, vend_nak, coin_reject, change_pulse, change_busy, fond},
                {22'd0, e.val});
        end
      end
      prev_fond = fond;
      prev_busy = change_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    coin_1 = 0; coin_2 = 0; coin_5 = 0; vend_req = 0; vend_price = 0; cancel = 0; rst = 1;
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("reset_fond", fond, 0);
    check("reset_pulses", {vend_ack, vend_nak, coin_reject, change_pulse}, 4'b0000);
    check("reset_busy", change_busy, 0);
    #1;
    prev_fond = fond;
    prev_busy = change_busy;
    mon_en = 1'b1;

    // Coin credit: 5, 5, 2
    drv(0, 0, 1, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 5);  idle();
    drv(0, 0, 1, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 10); idle();
    drv(0, 1, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 12); idle();
    // Held coin counts once
    drv(1, 0, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 13);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    idle();
    // Climb to 30, then saturation boundary
    drv(0, 0, 1, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 18); idle();
    drv(0, 0, 1, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 23); idle();
    drv(0, 0, 1, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 28); idle();
    drv(0, 1, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 30); idle();
    drv(0, 1, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 1, 0, 0, 30); idle();
    drv(1, 0, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 31); idle();
    drv(1, 0, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 1, 0, 0, 31); idle();
    // Vends: ack, ack, nak
    drv(0, 0, 0, 1, 19, 0, 0); expect_evt(last_edge, 1, 0, 0, 0, 0, 12);
    drv(0, 0, 0, 1, 8, 0, 0);  expect_evt(last_edge, 1, 0, 0, 0, 0, 4);
    drv(0, 0, 0, 1, 5, 0, 0);  expect_evt(last_edge, 0, 1, 0, 0, 0, 4);
    // Vend exact balance plus coin in the same cycle
    drv(0, 1, 0, 1, 4, 0, 0);  expect_evt(last_edge, 1, 0, 0, 0, 0, 2); idle();
    // Price 0 acks with no debit
    drv(0, 0, 0, 1, 0, 0, 0);  expect_evt(last_edge, 1, 0, 0, 0, 0, 2); idle();
    // Two coins at once: 5 credited, 1 rejected
    drv(1, 0, 1, 0, 0, 0, 0);  expect_evt(last_edge, 0, 0, 1, 0, 0, 7); idle();
    // Nak with a coin: coin still credited
    drv(0, 0, 1, 1, 9, 0, 0);  expect_evt(last_edge, 0, 1, 0, 0, 0, 12); idle();
    // Cancel ignored alongside a vend
    drv(0, 0, 0, 1, 2, 1, 0);  expect_evt(last_edge, 1, 0, 0, 0, 0, 10); idle();

`ifdef COIN_BANK_CHANGE_EN
    begin
      int k, a;
      drv(0, 0, 0, 1, 7, 0, 0); expect_evt(last_edge, 1, 0, 0, 0, 0, 3);
      k = last_edge + 2;
      idle_to(k);
      drv(0, 0, 0, 0, 0, 1, 0); expect_evt(k, 0, 0, 0, 0, 1, 3);
      idle();
      drv(1, 0, 0, 0, 0, 0, 0); expect_evt(k + 2, 0, 0, 1, 0, 1, 3);
      expect_evt(k + 4, 0, 0, 0, 1, 1, 2);
      idle_to(k + 6);
      drv(0, 0, 0, 1, 1, 0, 0); expect_evt(k + 6, 0, 1, 0, 0, 1, 2);
      expect_evt(k + 8, 0, 0, 0, 1, 1, 1);
      idle_to(k + 9);
      drv(0, 0, 0, 0, 0, 1, 0);
      expect_evt(k + 12, 0, 0, 0, 1, 0, 0);
      idle_to(k + 16);
      // Reset in the middle of a payout
      a = last_edge + 1;
      drv(0, 1, 0, 0, 0, 0, 0); expect_evt(a, 0, 0, 0, 0, 0, 2); idle();
      drv(1, 0, 0, 0, 0, 0, 0); expect_evt(a + 2, 0, 0, 0, 0, 0, 3); idle();
      k = a + 4;
      drv(0, 0, 0, 0, 0, 1, 0); expect_evt(k, 0, 0, 0, 0, 1, 3);
      expect_evt(k + 4, 0, 0, 0, 1, 1, 2);
      idle_to(k + 6);
      drv(0, 0, 0, 0, 0, 0, 1); expect_evt(k + 6, 0, 0, 0, 0, 0, 0);
      idle_to(k + 20);
    end
`else
    begin
      int k;
      k = last_edge + 1;
      drv(0, 0, 0, 0, 0, 1, 0); expect_evt(k, 0, 0, 0, 0, 0, 0);
      idle_to(k + 12);
      drv(0, 0, 0, 0, 0, 1, 0);
      idle();
      drv(1, 0, 0, 0, 0, 0, 0); expect_evt(last_edge, 0, 0, 0, 0, 0, 1);
      idle();
    end
`endif

    repeat (6) idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_bank.md
# coin_bank

Credit accumulator that sits directly upstream of the `cafea` beverage controller and produces its `fond` credit input. It detects coin insertions of 1, 2 and 5 units and keeps a saturating credit balance. It debits that balance on a vend request from the controller and answers with ack or nak. On cancel it pays the remaining credit back as paced change pulses.

## Interface
Parameters:
- `CREDIT_W`, default 5: width of the credit balance.
- `MAX_CREDIT`, default 31: maximum balance; must be ≤ 2^CREDIT_W−1.
- `CHANGE_GAP`, default 4: cycles between change pulses; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `coin_1` in 1: 1-unit coin sensor (level); counted on its rising edge.
- `coin_2` in 1: 2-unit coin sensor (level); counted on its rising edge.
- `coin_5` in 1: 5-unit coin sensor (level); counted on its rising edge.
- `vend_req` in 1: one-cycle debit request from the controller.
- `vend_price` in CREDIT_W: price, sampled with `vend_req`.
- `cancel` in 1: one-cycle request to return the credit.
- `fond` out CREDIT_W: registered credit balance; feeds `cafea.fond`.
- `vend_ack` out 1: one-cycle pulse; debit performed.
- `vend_nak` out 1: one-cycle pulse; insufficient funds or busy.
- `coin_reject` out 1: one-cycle pulse; the coin was not credited.
- `change_busy` out 1: high while change is being paid out.
- `change_pulse` out 1: one-cycle pulse per unit returned.

## Operation
- Coin edge detect:
  - One previous-value register per coin input.
  - Edge = input & ~prev.
  - Multiple edges in one cycle: only the highest value (5 > 2 > 1) is considered; the others raise `coin_reject`.
- Coin credit:
  - Accepted when the resulting balance is ≤ MAX_CREDIT; the balance then increases by the coin value.
  - Otherwise `fond` is unchanged and `coin_reject` pulses. There is no partial credit.
- States:
  - IDLE: accumulate credit, serve vend requests.
  - CHANGE: pay out credit.
- Vend (IDLE):
  - If `vend_price` ≤ `fond`, the balance decreases by the price and `vend_ack` pulses.
  - Otherwise `fond` is unchanged and `vend_nak` pulses.
  - Price 0 gives an ack with no debit.
- Vend + coin in the same cycle:
  - Funds are checked against the old `fond`.
  - After an ack, the coin is added to `fond − price` under the same MAX_CREDIT rule.
  - After a nak, the coin is handled normally.
- Cancel (IDLE):
  - `fond` = 0: no-op.
  - Otherwise go to CHANGE.
  - Cancel is ignored when `vend_req` is high in the same cycle.
  - A coin arriving together with cancel is rejected.
- CHANGE:
  - One unit is paid out every CHANGE_GAP cycles: `change_pulse` high and `fond` decremented on the same edge.
  - When `fond` reaches 0, return to IDLE and drop `change_busy` on that same edge.
  - All coins are rejected.
  - `vend_req` answers `vend_nak`.
  - `cancel` is ignored.
- Arithmetic: unsigned, CREDIT_W bits. The coin sum is computed at CREDIT_W+1 bits before comparing against MAX_CREDIT, so it cannot wrap.

## Timing
- Reset values:
  - `fond` = 0, all pulse outputs 0, `change_busy` = 0.
  - State IDLE, previous-value registers 0, gap counter 0.
- Coin latency: a rising edge sampled at edge k updates `fond` or `coin_reject` after edge k, i.e. visible in cycle k+1.
- A coin held high for many cycles counts once; a new coin needs a low cycle first.
- Vend latency: `vend_req` sampled at edge k gives `vend_ack`/`vend_nak` and the updated `fond` after edge k, for exactly one cycle.
- Change timing:
  - Cancel sampled at edge k: `change_busy` = 1 after edge k and the gap counter loads CHANGE_GAP−1.
  - The counter decrements each cycle; when it is 0 at an edge, the pulse and decrement happen and the counter reloads.
  - First `change_pulse` after edge k+CHANGE_GAP, then every CHANGE_GAP cycles.
- Reset mid-CHANGE: immediate return to IDLE with `fond` = 0; no further pulses.

## Configuration
- `COIN_BANK_CHANGE_EN` defined:
  - The CHANGE state, gap counter and change behaviour exist as described above.
- `COIN_BANK_CHANGE_EN` undefined:
  - The CHANGE state and gap counter are removed.
  - Cancel in IDLE clears `fond` to 0 after the sampling edge; the credit is forfeited.
  - `change_busy` and `change_pulse` are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then coin edges 5, 5, 2 → `fond` goes 5, 10, 12, each one cycle after its edge; `coin_reject` stays 0.
- `fond` = 30, insert 2 → `coin_reject` pulses, `fond` stays 30; insert 1 → `fond` = 31.
- `fond` = 12, `vend_req` with price 8 → `vend_ack` 1 cycle, `fond` = 4; then price 5 → `vend_nak`, `fond` stays 4.
- `fond` = 4, `vend_req` price 4 plus `coin_2` edge in the same cycle → `vend_ack`, `fond` = 2.
- Change enabled, `fond` = 3, CHANGE_GAP = 4, cancel at edge k → `change_busy` from k+1; pulses at k+4, k+8, k+12; `fond` 2, 1, 0; `change_busy` low after k+12; a coin during payout is rejected.
- `rst` asserted while `fond` = 2 mid-payout → next cycle `fond` = 0, `change_busy` = 0, no further pulses.
- Change disabled, `fond` = 7, cancel → `fond` = 0 next cycle, `change_pulse` never asserts.
